// File: rtl/dm_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM state encoding,
// byte-to-word shift and the default word width.
package dm_arbiter_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int BYTE_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational 2-way winner select for the data-memory arbiter.
// Optional feature macro: DM_ARB_RR_EN (round-robin on ties when defined,
// fixed priority to port 0 otherwise).
module dm_arb_pick (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_valid,
  output logic       o_grant
);

  assign o_valid = |i_req;

`ifdef DM_ARB_RR_EN
  // On a tie the port that was not granted last wins; a lone requester always wins.
  always_comb begin
    if (i_req == 2'b11) begin
      o_grant = ~i_last_grant;
    end else begin
      o_grant = i_req[1];
    end
  end
`else
  // Fixed priority: port 1 wins only when port 0 is not requesting.
  assign o_grant = i_req[1] & ~i_req[0];

  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port data memory (synchronous
// write, combinational read, word-indexed). Port 0 is the CPU MEM stage,
// port 1 the loader/debug port. Each access takes IDLE -> ACCESS -> RESP.
// Optional feature macro: DM_ARB_RR_EN (round-robin tie break).
module dm_arbiter #(
  parameter int MEM_SIZE   = 128,
  parameter int WORD_WIDTH = dm_arbiter_pkg::WORD_WIDTH,
  parameter int IDX_W      = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [WORD_WIDTH-1:0] p0_addr,
  input  logic [WORD_WIDTH-1:0] p0_wdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [WORD_WIDTH-1:0] p1_addr,
  input  logic [WORD_WIDTH-1:0] p1_wdata,
  output logic                  p0_ack,
  output logic                  p0_err,
  output logic [WORD_WIDTH-1:0] p0_rdata,
  output logic                  p1_ack,
  output logic                  p1_err,
  output logic [WORD_WIDTH-1:0] p1_rdata,
  output logic [WORD_WIDTH-1:0] dm_addr,
  output logic [WORD_WIDTH-1:0] dm_wdata,
  output logic                  dm_we,
  output logic                  dm_re,
  input  logic [WORD_WIDTH-1:0] dm_rdata
);

  import dm_arbiter_pkg::*;

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_owner;
  logic                  r_we;
  logic                  r_err;
  logic [IDX_W-1:0]      r_word;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic [WORD_WIDTH-1:0] r_p0_rdata;
  logic [WORD_WIDTH-1:0] r_p1_rdata;

  logic                  w_grant_valid;
  logic                  w_grant;
  logic                  w_last_grant;
  logic                  w_sel_we;
  logic [WORD_WIDTH-1:0] w_sel_addr;
  logic [WORD_WIDTH-1:0] w_sel_wdata;
  logic [WORD_WIDTH-1:0] w_sel_word;
  logic                  w_sel_err;
  logic                  w_take;

  dm_arb_pick u_pick (
    .i_req        ({p1_req, p0_req}),
    .i_last_grant (w_last_grant),
    .o_valid      (w_grant_valid),
    .o_grant      (w_grant)
  );

  // The winner's request is what gets latched; the error is decided once, at grant.
  assign w_sel_we    = w_grant ? p1_we    : p0_we;
  assign w_sel_addr  = w_grant ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_grant ? p1_wdata : p0_wdata;
  assign w_sel_word  = w_sel_addr >> BYTE_SHIFT;
  assign w_sel_err   = (w_sel_addr[BYTE_SHIFT-1:0] != '0) ||
                       (w_sel_word >= WORD_WIDTH'(MEM_SIZE));
  assign w_take      = (r_state == ST_IDLE) && w_grant_valid;

`ifdef DM_ARB_RR_EN
  logic r_last_grant;

  // Remember which port won the most recent grant for the tie break.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b0;
    end else if (w_take) begin
      r_last_grant <= w_grant;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = 1'b0;
`endif

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latch the granted request in IDLE; capture read data at the close of ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_word     <= '0;
      r_wdata    <= '0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      if (w_take) begin
        r_owner <= w_grant;
        r_we    <= w_sel_we;
        r_err   <= w_sel_err;
        r_word  <= w_sel_word[IDX_W-1:0];
        r_wdata <= w_sel_wdata;
      end
      if ((r_state == ST_ACCESS) && !r_we && !r_err) begin
        if (r_owner) begin
          r_p1_rdata <= dm_rdata;
        end else begin
          r_p0_rdata <= dm_rdata;
        end
      end
    end
  end

  // Next state and strobes; memory strobes exist only in ACCESS, acks only in RESP.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    dm_we        = 1'b0;
    dm_re        = 1'b0;
    p0_ack       = 1'b0;
    p0_err       = 1'b0;
    p1_ack       = 1'b0;
    p1_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        dm_we        = r_we & ~r_err;
        dm_re        = ~r_we & ~r_err;
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (r_owner) begin
          p1_ack = 1'b1;
          p1_err = r_err;
        end else begin
          p0_ack = 1'b1;
          p0_err = r_err;
        end
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Address and write data hold their last latched values outside ACCESS.
  assign dm_addr  = WORD_WIDTH'(r_word);
  assign dm_wdata = r_wdata;
  assign p0_rdata = r_p0_rdata;
  assign p1_rdata = r_p1_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter with a behavioural DM and a scoreboard.
// Build with +define+DM_ARB_RR_EN to exercise the round-robin variant.
module tb_dm_arbiter;

  localparam int MEM_SIZE = 128;
  localparam int W        = 32;

  typedef struct {
    logic         err;
    logic [W-1:0] rdata;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         p0_req, p0_we, p1_req, p1_we;
  logic [W-1:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic         p0_ack, p0_err, p1_ack, p1_err;
  logic [W-1:0] p0_rdata, p1_rdata;
  logic [W-1:0] dm_addr, dm_wdata, dm_rdata;
  logic         dm_we, dm_re;

  logic [W-1:0] mem     [MEM_SIZE];
  logic [W-1:0] ref_mem [MEM_SIZE];
  logic [W-1:0] shadow  [2];
  logic         preload;

  exp_t         q0[$];
  exp_t         q1[$];
  exp_t         mon_e;
  int           grant_log[$];
  int           total = 0;
  int           bad   = 0;
  int           we_cycles = 0;
  int           re_cycles = 0;
  logic [W-1:0] last_we_addr = '0;
  bit           allow_withdraw = 1'b0;
  logic         prev_req0 = 1'b0, prev_req1 = 1'b0;
  logic         ackd0 = 1'b0, ackd1 = 1'b0;

  always #5 clk = ~clk;

  dm_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk      (clk),
    .reset    (reset),
    .p0_req   (p0_req),
    .p0_we    (p0_we),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p1_req   (p1_req),
    .p1_we    (p1_we),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p0_ack   (p0_ack),
    .p0_err   (p0_err),
    .p0_rdata (p0_rdata),
    .p1_ack   (p1_ack),
    .p1_err   (p1_err),
    .p1_rdata (p1_rdata),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_we    (dm_we),
    .dm_re    (dm_re),
    .dm_rdata (dm_rdata)
  );

  // Behavioural DM: combinational read, synchronous write, preloaded with a per-word pattern.
  assign dm_rdata = mem[dm_addr[6:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= 32'hA000_0000 + W'(i);
    end else if (dm_we) begin
      mem[dm_addr[6:0]] <= dm_wdata;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= W'(MEM_SIZE));
  endfunction

  // Reference model: decide error/rdata for a request and queue the expectation.
  task automatic push_exp(input int port, input logic we, input logic [W-1:0] addr,
                          input logic [W-1:0] wdata);
    exp_t e;
    e.err = model_err(addr);
    if (!e.err) begin
      if (we) ref_mem[addr[8:2]] = wdata;
      else    shadow[port]       = ref_mem[addr[8:2]];
    end
    e.rdata = shadow[port];
    if (port == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  task automatic drive_req(input int port, input logic req, input logic we,
                           input logic [W-1:0] addr, input logic [W-1:0] wdata);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  // One access from IDLE; the ack must land in the third cycle counting the request cycle.
  task automatic do_access(input int port, input logic we, input logic [W-1:0] addr,
                           input logic [W-1:0] wdata, input bit drop, input string tag);
    int lat;
    bit got;
    push_exp(port, we, addr, wdata);
    drive_req(port, 1'b1, we, addr, wdata);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = (port == 0) ? p0_ack : p1_ack;
    end
    check({tag, "_ack_seen"}, W'(got), 1);
    check({tag, "_latency"}, W'(lat), 3);
    @(posedge clk);
    #1;
    if (drop) drive_req(port, 1'b0, we, addr, wdata);
  endtask

  // Ack monitor: pops the scoreboard, logs grant order, counts DM strobes, polices req holding.
  always @(negedge clk) begin
    if (dm_we) begin
      we_cycles++;
      last_we_addr = dm_addr;
    end
    if (dm_re) re_cycles++;
    if (p0_req && !prev_req0) ackd0 = 1'b0;
    if (p1_req && !prev_req1) ackd1 = 1'b0;
    if (p0_ack) begin
      ackd0 = 1'b1;
      grant_log.push_back(0);
      check("p0_ack_expected", W'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        mon_e = q0.pop_front();
        check("p0_err", W'(p0_err), W'(mon_e.err));
        check("p0_rdata", p0_rdata, mon_e.rdata);
      end
    end
    if (p1_ack) begin
      ackd1 = 1'b1;
      grant_log.push_back(1);
      check("p1_ack_expected", W'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        mon_e = q1.pop_front();
        check("p1_err", W'(p1_err), W'(mon_e.err));
        check("p1_rdata", p1_rdata, mon_e.rdata);
      end
    end
    if (prev_req0 && !p0_req && !allow_withdraw) check("p0_req_held_until_ack", W'(ackd0), 1);
    if (prev_req1 && !p1_req && !allow_withdraw) check("p1_req_held_until_ack", W'(ackd1), 1);
    prev_req0 = p0_req;
    prev_req1 = p1_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap, log0, port;
    bit got;
    int exp_order [4];
    logic [W-1:0] tie_addr [2];

`ifdef DM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    tie_addr[0] = 32'h10;
    tie_addr[1] = 32'h20;

    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 32'hA000_0000 + W'(i);
    shadow[0] = '0;
    shadow[1] = '0;
    drive_req(0, 1'b0, 1'b0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    reset   = 1'b1;
    preload = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;

    // Reset state.
    check("rst_dm_we", W'(dm_we), 0);
    check("rst_dm_re", W'(dm_re), 0);
    check("rst_p0_ack", W'(p0_ack), 0);
    check("rst_p1_ack", W'(p1_ack), 0);
    check("rst_p0_err", W'(p0_err), 0);
    check("rst_p1_err", W'(p1_err), 0);
    check("rst_dm_addr", dm_addr, 0);
    check("rst_dm_wdata", dm_wdata, 0);
    check("rst_p0_rdata", p0_rdata, 0);
    check("rst_p1_rdata", p1_rdata, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // p0 write then read back of byte address 0x10 (word 4).
    snap = we_cycles;
    do_access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, "wr10");
    check("wr10_we_cycles", W'(we_cycles - snap), 1);
    check("wr10_dm_addr", last_we_addr, 4);
    do_access(0, 1'b0, 32'h10, '0, 1'b1, "rd10");
    check("rd10_rdata_held", p0_rdata, 32'hDEAD_BEEF);

    // p1 misaligned and out-of-range accesses must not touch the DM.
    snap = we_cycles;
    do_access(1, 1'b1, 32'h202, 32'h1234_5678, 1'b1, "p1_wr202");
    check("p1_wr202_no_write", W'(we_cycles - snap), 0);
    do_access(1, 1'b0, 32'h200, '0, 1'b1, "p1_rd200");
    do_access(1, 1'b0, 32'h0, '0, 1'b1, "p1_rd0");

    // Both ports hold read requests for four grants; last grant so far was p1.
    log0 = grant_log.size();
    allow_withdraw = 1'b1;
    push_exp(0, 1'b0, tie_addr[0], '0);
    push_exp(1, 1'b0, tie_addr[1], '0);
    drive_req(0, 1'b1, 1'b0, tie_addr[0], '0);
    drive_req(1, 1'b1, 1'b0, tie_addr[1], '0);
    for (int n = 0; n < 4; n++) begin
      got  = 1'b0;
      port = 0;
      for (int i = 0; i < 12 && !got; i++) begin
        @(negedge clk);
        if (p0_ack || p1_ack) begin
          got  = 1'b1;
          port = p0_ack ? 0 : 1;
        end
      end
      check("tie_ack_seen", W'(got), 1);
      @(posedge clk);
      #1;
      if (n < 3) begin
        push_exp(port, 1'b0, tie_addr[port], '0);
      end else begin
        drive_req(0, 1'b0, 1'b0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    q0.delete();
    q1.delete();
    allow_withdraw = 1'b0;
    check("tie_grant_count", W'(grant_log.size() - log0), 4);
    for (int k = 0; k < 4; k++) begin
      if (log0 + k < grant_log.size()) check("tie_order", W'(grant_log[log0 + k]), W'(exp_order[k]));
    end

    // p0 read of word 128 is out of range: no DM read, rdata unchanged.
    snap = re_cycles;
    do_access(0, 1'b0, 32'h200, '0, 1'b1, "p0_rd200");
    check("p0_rd200_no_read", W'(re_cycles - snap), 0);
    check("p0_rd200_rdata_kept", p0_rdata, 32'hDEAD_BEEF);

    // Reset during ACCESS of a write of 0x55 to 0x8: strobe drops, no ack, no commit.
    allow_withdraw = 1'b1;
    drive_req(0, 1'b1, 1'b1, 32'h8, 32'h55);
    @(negedge clk);
    @(negedge clk);
    check("rstmid_dm_we_access", W'(dm_we), 1);
    check("rstmid_dm_addr_access", dm_addr, 2);
    #1;
    reset = 1'b1;
    #1;
    check("rstmid_dm_we_cleared", W'(dm_we), 0);
    check("rstmid_p0_ack", W'(p0_ack), 0);
    check("rstmid_dm_addr_cleared", dm_addr, 0);
    check("rstmid_dm_wdata_cleared", dm_wdata, 0);
    drive_req(0, 1'b0, 1'b0, '0, '0);
    shadow[0] = '0;
    shadow[1] = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    allow_withdraw = 1'b0;
    check("rstmid_p0_rdata_cleared", p0_rdata, 0);
    do_access(0, 1'b0, 32'h8, '0, 1'b1, "rd8_after_rst");

    // Back-to-back reads: second request presented at the edge ending the first ack.
    do_access(0, 1'b0, 32'h0, '0, 1'b0, "b2b_first");
    do_access(0, 1'b0, 32'h4, '0, 1'b1, "b2b_second");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory (DM: synchronous write, combinational read, word-indexed) between two requesters.
- Port 0 is the CPU MEM stage; port 1 is the program loader / debug port.
- Byte-address request/acknowledge handshake per port.
- Drives the DM address, write-data and control lines, and returns registered read data plus an error flag.

Parameters:
- MEM_SIZE, 128, DM depth in words; must match the DM instance.
- WORD_WIDTH, `WORD_WIDTH (32), data and address width.
- IDX_W, $clog2(MEM_SIZE), width of the word-index field.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- p0_req / p1_req  in  1  request; held high until the matching ack.
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req is high.
- p0_addr / p1_addr  in  WORD_WIDTH  byte address; stable while req is high.
- p0_wdata / p1_wdata  in  WORD_WIDTH  write data; stable while req is high.
- p0_ack / p1_ack  out  1  one-cycle completion pulse.
- p0_err / p1_err  out  1  valid with ack; 1 = misaligned or out-of-range access.
- p0_rdata / p1_rdata  out  WORD_WIDTH  read data; valid with ack and held until the next ack on that port.
- dm_addr  out  WORD_WIDTH  word index to the DM memAddr input (byte address >> 2, zero-extended).
- dm_wdata  out  WORD_WIDTH  to DM dataToWrite.
- dm_we  out  1  to DM toWrite.
- dm_re  out  1  to DM toRead.
- dm_rdata  in  WORD_WIDTH  from DM outData.

Behaviour:
- Reset values: state IDLE; all acks, errs, dm_we and dm_re at 0; dm_addr, dm_wdata and all rdata at 0; round-robin pointer at 0.
- FSM has three states.
  - IDLE: if any req is high, pick a winner. Latch owner, we, addr, wdata and err. Go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive dm_addr from the latched word index. Assert dm_we = we & ~err and dm_re = ~we & ~err. The write commits at the closing edge. On a read with no error, the owner's rdata register captures dm_rdata at that same edge. Go to RESP.
  - RESP: pulse the owner's ack for one cycle, with err valid. Go to IDLE.
- Error rule: err = (addr[1:0] != 0) or (addr >> 2 >= MEM_SIZE).
  - No DM write occurs on an errored access.
  - rdata is left unchanged.
- Latency: 3 cycles from req sampled in IDLE to the ack cycle.
  - Throughput is one access per 3 cycles.
  - The requester drops req, or presents a new request, at the edge that ends its ack cycle. IDLE then sees the new value.
- Arbitration runs only in IDLE; a transaction in flight is never preempted.
  - Simultaneous requests are resolved per the Optional Feature.
  - A lone requester is always granted.
- dm_addr and dm_wdata hold their last values outside ACCESS; dm_we and dm_re are 0 outside ACCESS.
- Reset asserted mid-transaction:
  - Outputs clear immediately; dm_we drops before the next edge, so no write commits.
  - The pending transaction is dropped with no ack; the requester reissues it.
- Protocol violation (req dropped before ack): the transaction still completes and the ack still pulses. A bench assertion flags it.

Optional Feature:
- Macro DM_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie, the port not granted last wins. The pointer updates on each grant.
- Undefined: fixed priority, port 0 (CPU) always wins ties. The pointer logic is not generated.

Decomposition:
- Shared package / constants header holds:
  - the state encoding localparams (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2);
  - the byte-to-word shift constant (2);
  - WORD_WIDTH.
- One natural sub-module, dm_arb_pick: combinational 2-way winner select from req[1:0] and last_grant. It contains the DM_ARB_RR_EN ifdef.

Test Plan:
- Reset, then p0 write addr 0x10 data 0xDEADBEEF, then p0 read 0x10 -> dm_we high for exactly one cycle with dm_addr = 4; the read acks 3 cycles after req with p0_rdata = 0xDEADBEEF and p0_err = 0.
- p0 and p1 request reads in the same cycle, held for 4 transactions -> without the macro, p0 acks every time while p1 waits; with the macro, grants alternate p0, p1, p0, p1.
- p1 writes addr 0x0202 -> p1_err = 1, dm_we never asserts, a follow-up read of 0x200 returns the prior contents.
- p0 reads addr 0x200 (word 128, MEM_SIZE = 128) -> p0_err = 1, dm_re stays 0, p0_rdata holds its previous value.
- Reset pulsed during ACCESS of a write of 0x55 to 0x8 -> no ack; a read of 0x8 after reset returns the old value, not 0x55.
- p0 issues back-to-back reads of 0x0 and 0x4, presenting the second request at the edge that ends the first ack -> second ack arrives exactly 3 cycles after the first; no idle gap beyond the IDLE cycle.
